// File: rtl/cell_lane_processor.sv
// rtl/cell_lane_processor.sv - two-stage multi-lane pixel ALU with valid/ready flow control
//
// Purpose:
//   Applies one of eight per-lane pixel operations to LANES packed cells per beat.
//   Stage 1 registers the accepted operands and opcode. Stage 2 registers the result,
//   the per-lane clamp flags and out_valid. Both stages advance together under
//   backpressure, so the block sustains one beat per cycle.
//
// Parameters:
//   CELL_DEPTH - bits per cell (4..16)
//   LANES      - cells per beat (1..16)
//   CNT_WIDTH  - width of the delivered-beat counter
//
// Ports:
//   clk            - single clock; all logic updates on its rising edge
//   rst            - synchronous, active-high reset
//   in_valid       - input beat valid
//   in_ready       - block can take an input beat this cycle
//   cell_a         - operand A, lane i at [i*CELL_DEPTH +: CELL_DEPTH]
//   cell_b         - operand B, same packing as cell_a
//   user_in        - scalar operand shared by every lane of the beat
//   opcode         - operation for the beat
//   out_valid      - output beat valid
//   out_ready      - downstream accepts the output beat
//   processed_cell - result, same packing as cell_a
//   sat_flag       - per-lane flag, set when that lane's result was clamped
//   beat_count     - count of delivered output beats; wraps at 2^CNT_WIDTH

module cell_lane_processor #(
  parameter int CELL_DEPTH = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*CELL_DEPTH-1:0] cell_a,
  input  logic [LANES*CELL_DEPTH-1:0] cell_b,
  input  logic [CELL_DEPTH-1:0]       user_in,
  input  logic [2:0]                  opcode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*CELL_DEPTH-1:0] processed_cell,
  output logic [LANES-1:0]            sat_flag,
  output logic [CNT_WIDTH-1:0]        beat_count
);

  typedef enum logic [2:0] {
    OP_PASS   = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_INV    = 3'd3,
    OP_AVG    = 3'd4,
    OP_THRESH = 3'd5,
    OP_BRIGHT = 3'd6,
    OP_MAXAB  = 3'd7
  } op_e;

  localparam logic [CELL_DEPTH-1:0] CELL_MAX = '1;

  // Stage 1 registers
  logic                        s1_valid_q;
  logic [LANES*CELL_DEPTH-1:0] s1_a_q;
  logic [LANES*CELL_DEPTH-1:0] s1_b_q;
  logic [CELL_DEPTH-1:0]       s1_u_q;
  op_e                         s1_op_q;

  // Stage 2 registers
  logic                        out_valid_q;
  logic [LANES*CELL_DEPTH-1:0] result_q;
  logic [LANES-1:0]            sat_q;
  logic [CNT_WIDTH-1:0]        count_q;

  // Stage 2 next-state data, computed from stage 1
  logic [LANES*CELL_DEPTH-1:0] result_d;
  logic [LANES-1:0]            sat_d;

  logic s2_load;
  logic s1_load;

  // Stage 2 may take a new beat whenever its current one is absent or leaving.
  assign s2_load = !out_valid_q || out_ready;
  // Stage 1 may take a new beat when empty or when its beat moves into stage 2.
  // Reset forces not-ready so nothing is accepted while the pipeline is cleared.
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = !rst && s1_load;

  // Per-lane datapath; each lane sees only its own slice, so no carry crosses lanes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [CELL_DEPTH-1:0] lane_a;
    logic [CELL_DEPTH-1:0] lane_b;
    logic [CELL_DEPTH:0]   sum_ab;
    logic [CELL_DEPTH:0]   sum_au;
    logic [CELL_DEPTH-1:0] lane_res;
    logic                  lane_sat;

    assign lane_a = s1_a_q[g*CELL_DEPTH +: CELL_DEPTH];
    assign lane_b = s1_b_q[g*CELL_DEPTH +: CELL_DEPTH];
    // One extra bit holds the carry used both for clamping and for the average.
    assign sum_ab = {1'b0, lane_a} + {1'b0, lane_b};
    assign sum_au = {1'b0, lane_a} + {1'b0, s1_u_q};

    always_comb begin
      lane_res = '0;
      lane_sat = 1'b0;
      case (s1_op_q)
        OP_PASS: lane_res = lane_a;
        OP_ADD: begin
          if (sum_ab[CELL_DEPTH]) begin
            lane_res = CELL_MAX;
            lane_sat = 1'b1;
          end else begin
            lane_res = sum_ab[CELL_DEPTH-1:0];
          end
        end
        OP_SUB: begin
          if (lane_a < lane_b) begin
            lane_res = '0;
            lane_sat = 1'b1;
          end else begin
            lane_res = lane_a - lane_b;
          end
        end
        OP_INV: lane_res = CELL_MAX - lane_a;
        OP_AVG: lane_res = sum_ab[CELL_DEPTH:1];
        OP_THRESH: lane_res = (lane_a >= s1_u_q) ? CELL_MAX : '0;
        OP_BRIGHT: begin
          if (sum_au[CELL_DEPTH]) begin
            lane_res = CELL_MAX;
            lane_sat = 1'b1;
          end else begin
            lane_res = sum_au[CELL_DEPTH-1:0];
          end
        end
        OP_MAXAB: lane_res = (lane_a > lane_b) ? lane_a : lane_b;
        default: begin
          lane_res = '0;
          lane_sat = 1'b0;
        end
      endcase
    end

    assign result_d[g*CELL_DEPTH +: CELL_DEPTH] = lane_res;
    assign sat_d[g] = lane_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= '0;
      count_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        // Operand registers only change for a real beat.
        if (in_valid) begin
          s1_a_q  <= cell_a;
          s1_b_q  <= cell_b;
          s1_u_q  <= user_in;
          s1_op_q <= op_e'(opcode);
        end
      end

      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q <= result_d;
          sat_q    <= sat_d;
        end
      end

      if (out_valid_q && out_ready) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign processed_cell = result_q;
  assign sat_flag       = sat_q;
  assign beat_count     = count_q;

endmodule

// File: tb/tb_cell_lane_processor.sv
// tb/tb_cell_lane_processor.sv - self-checking bench for cell_lane_processor

module tb_cell_lane_processor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] cell_a = '0;
  logic [31:0] cell_b = '0;
  logic [7:0]  user_in = '0;
  logic [2:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] processed_cell;
  logic [3:0]  sat_flag;
  logic [3:0]  beat_count;

  cell_lane_processor #(
    .CELL_DEPTH(8),
    .LANES(4),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cell_a(cell_a),
    .cell_b(cell_b),
    .user_in(user_in),
    .opcode(opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .processed_cell(processed_cell),
    .sat_flag(sat_flag),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  u;
    logic [31:0] res;
    logic [3:0]  sat;
  } vec_t;

  vec_t        vt[12];
  logic [35:0] sb_q[$];
  logic [35:0] cur_exp;
  logic [35:0] mon_exp;
  int          checks = 0;
  int          errors = 0;
  int          n_deliv = 0;

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    in_valid = 1'b1;
    opcode   = vt[idx].op;
    cell_a   = vt[idx].a;
    cell_b   = vt[idx].b;
    user_in  = vt[idx].u;
    cur_exp  = {vt[idx].sat, vt[idx].res};
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_beat_count", 64'(beat_count), 64'd0);
    check("rst_cell", 64'(processed_cell), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 12 && sb_q.size() != 0; k++) tick();
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard: push on acceptance, pop and compare on delivery.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_deliv++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %0h expected none", {sat_flag, processed_cell});
        end else begin
          mon_exp = sb_q.pop_front();
          if ({sat_flag, processed_cell} !== mon_exp) begin
            errors++;
            $display("FAIL sb_beat got %0h expected %0h", {sat_flag, processed_cell}, mon_exp);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int last;
    int nv;
    int acc;
    int d0;
    logic seen;
    logic [36:0] held;

    vt[0]  = '{3'd1, pk(250, 10, 0, 128), pk(10, 5, 0, 128), 8'd0, pk(255, 15, 0, 255), 4'b1001};
    vt[1]  = '{3'd2, pk(5, 200, 0, 7), pk(10, 100, 0, 7), 8'd0, pk(0, 100, 0, 0), 4'b0001};
    vt[2]  = '{3'd3, 32'h0F0F0F0F, 32'h12345678, 8'd0, 32'hF0F0F0F0, 4'b0000};
    vt[3]  = '{3'd5, pk(127, 128, 255, 0), pk(1, 2, 3, 4), 8'd128, pk(0, 255, 255, 0), 4'b0000};
    vt[4]  = '{3'd0, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(200, 3, 100, 255), 4'b0000};
    vt[5]  = '{3'd1, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(255, 10, 200, 255), 4'b1001};
    vt[6]  = '{3'd2, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(100, 0, 0, 254), 4'b0010};
    vt[7]  = '{3'd3, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(55, 252, 155, 0), 4'b0000};
    vt[8]  = '{3'd4, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(150, 5, 100, 128), 4'b0000};
    vt[9]  = '{3'd5, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(255, 0, 255, 255), 4'b0000};
    vt[10] = '{3'd6, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(255, 63, 160, 255), 4'b1001};
    vt[11] = '{3'd7, pk(200, 3, 100, 255), pk(100, 7, 100, 1), 8'd60, pk(200, 7, 100, 255), 4'b0000};

    tick();
    do_reset();

    // Single beats with latency checks: ADD, SUB, INV, THRESH.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("single_in_ready", 64'(in_ready), 64'd1);
      drive(i);
      tick();
      in_valid = 1'b0;
      check("lat_edge1_out_valid", 64'(out_valid), 64'd0);
      tick();
      check("lat_edge2_out_valid", 64'(out_valid), 64'd1);
      tick();
      check("single_beat_count", 64'(beat_count), 64'(i + 1));
    end

    // Back-to-back stream, opcodes 0..7.
    do_reset();
    out_ready = 1'b1;
    first = -1;
    last = -1;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(4 + k);
      else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        if (first < 0) first = k;
        last = k;
        nv++;
      end
    end
    check("stream_valid_cycles", 64'(nv), 64'd8);
    check("stream_consecutive", 64'(last - first + 1), 64'd8);
    check("stream_beat_count", 64'(beat_count), 64'd8);
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    // Backpressure: out_ready low for 5 cycles with in_valid high.
    out_ready = 1'b0;
    acc = 0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      drive(acc);
      if (in_ready) acc++;
      tick();
      if (k == 2) held = {out_valid, sat_flag, processed_cell};
    end
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_hold", 64'({out_valid, sat_flag, processed_cell}), 64'(held));
    check("stall_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    d0 = n_deliv;
    out_ready = 1'b1;
    drain("stall_drain");
    check("stall_delivered", 64'(n_deliv - d0), 64'd2);
    check("stall_beat_count", 64'(beat_count), 64'd10);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(5);
    tick();
    drive(6);
    tick();
    in_valid = 1'b0;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_beat_count", 64'(beat_count), 64'd0);
    d0 = n_deliv;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);
    check("midrst_no_deliv", 64'(n_deliv - d0), 64'd0);

    // Counter wrap at CNT_WIDTH=4: 17 beats leaves beat_count at 1.
    d0 = n_deliv;
    for (int k = 0; k < 17; k++) begin
      drive(k % 12);
      tick();
    end
    in_valid = 1'b0;
    drain("wrap_drain");
    check("wrap_delivered", 64'(n_deliv - d0), 64'd17);
    check("wrap_beat_count", 64'(beat_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
